toast_muldiv_seq: RTL

Iterative multiply/divide sequencer for the RV32M extension. It sits beside the EX-stage ALU and accepts one M-type operation at a time from the ID/EX boundary. While its shift-add or restoring-divide engine iterates, it holds the pipeline with a stall. When the operation finishes it presents a registered 32-bit result for one cycle, which the EX stage muxes into its ALU-result register.

---
 rtl/toast_pkg.sv | 31 +++
 rtl/toast_muldiv_core.sv | 60 ++++++
 rtl/toast_muldiv_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/toast_pkg.sv
// +------------------------------------------------------------------+
// | toast_pkg : shared types/constants for the RV32M muldiv sequencer |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package toast_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/toast_muldiv_core.sv
// +------------------------------------------------------------------+
// | toast_muldiv_core : 64-bit accumulator with one-step shift-add /  |
// |                     restoring shift-subtract, advanced by i_step  |
// | Revision          : 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module toast_muldiv_core
  import toast_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_opa,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc_step
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;

  // Upper half holds partial product / remainder, lower half the
  // multiplier bits still to consume / the quotient being built.
  always_comb begin
    w_addend   = r_acc[0] ? r_opb : '0;
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_ge       = (w_rem_sh >= {1'b0, r_opb});
    w_diff     = w_rem_sh[XLEN-1:0] - r_opb;
    o_acc_step = {w_sum, r_acc[XLEN-1:1]};
    if (i_is_div) begin
      o_acc_step = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                        : {r_acc[2*XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_opb <= '0;
    end else if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_opa};
      r_opb <= i_opb;
    end else if (i_step) begin
      r_acc <= o_acc_step;
    end
  end

endmodule

`default_nettype wire

// File: rtl/toast_muldiv_seq.sv
// +------------------------------------------------------------------+
// | toast_muldiv_seq : iterative RV32M multiply/divide sequencer      |
// | Option           : TOAST_MULDIV_EARLY_OUT_EN skips CALC for       |
// |                    div-by-zero, signed overflow, zero multiplies  |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module toast_muldiv_seq
  import toast_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [4:0] c_cnt_load = 5'(MULDIV_ITERS - 1);

  muldiv_state_t     r_state, w_next;
  muldiv_op_t        r_op;
  logic [XLEN-1:0]   r_op1, r_op2, r_result;
  logic [4:0]        r_cnt;

  logic              w_load, w_step, w_finish, w_early, w_accept;
  logic              w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2, w_div0;
  logic [XLEN-1:0]   w_abs1, w_abs2, w_quo, w_rem, w_calc_res, w_result;
  logic [2*XLEN-1:0] w_acc_step, w_prod;

  assign w_accept = start_i && !flush_i;
  assign w_is_div = r_op[2];
  assign w_sgn1   = (r_op != OP_MULHU) && (r_op != OP_DIVU) && (r_op != OP_REMU);
  assign w_sgn2   = w_sgn1 && (r_op != OP_MULHSU);
  assign w_neg1   = w_sgn1 && r_op1[XLEN-1];
  assign w_neg2   = w_sgn2 && r_op2[XLEN-1];
  assign w_abs1   = w_neg1 ? -r_op1 : r_op1;
  assign w_abs2   = w_neg2 ? -r_op2 : r_op2;
  assign w_div0   = (r_op2 == '0);

  toast_muldiv_core #(.XLEN(XLEN)) u_core (
    .i_clk      (clk_i),
    .i_rst_n    (resetn_i),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_is_div   (w_is_div),
    .i_opa      (w_abs1),
    .i_opb      (w_abs2),
    .o_acc_step (w_acc_step)
  );

  // Fixup works on the final step value so result_o is registered on
  // the same edge that enters DONE. A zero divisor keeps the all-ones
  // quotient the engine naturally produces.
  always_comb begin
    w_prod = (w_neg1 ^ w_neg2) ? -w_acc_step : w_acc_step;
    w_quo  = ((w_neg1 ^ w_neg2) && !w_div0) ? -w_acc_step[XLEN-1:0]
                                             : w_acc_step[XLEN-1:0];
    w_rem  = w_neg1 ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:                      w_calc_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_calc_res = w_quo;
      default:                     w_calc_res = w_rem;
    endcase
  end

`ifdef TOAST_MULDIV_EARLY_OUT_EN
  logic            w_ovf, w_mul0;
  logic [XLEN-1:0] w_early_res;

  assign w_ovf  = w_sgn1 && (r_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_op2 == '1);
  assign w_mul0 = (r_op1 == '0) || (r_op2 == '0);
  assign w_early = w_is_div ? (w_div0 || w_ovf) : w_mul0;

  // Overflow quotient equals the dividend itself (0x80000000).
  always_comb begin
    w_early_res = '0;
    if (w_is_div) begin
      if (w_div0) w_early_res = r_op[1] ? r_op1 : '1;
      else        w_early_res = r_op[1] ? '0 : r_op1;
    end
  end

  assign w_result = (r_state == ST_PREP) ? w_early_res : w_calc_res;
`else
  assign w_early  = 1'b0;
  assign w_result = w_calc_res;
`endif

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_PREP;
      ST_PREP: begin
        if (flush_i) begin
          w_next = ST_IDLE;
        end else begin
          w_load = 1'b1;
          if (w_early) begin
            w_next   = ST_DONE;
            w_finish = 1'b1;
          end else begin
            w_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          w_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == '0) begin
            w_next   = ST_DONE;
            w_finish = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_op1    <= '0;
      r_op2    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_accept) begin
        r_op  <= muldiv_op_t'(op_i);
        r_op1 <= op1_i;
        r_op2 <= op2_i;
      end
      if (w_load)      r_cnt <= c_cnt_load;
      else if (w_step) r_cnt <= r_cnt - 5'd1;
      if (w_finish)    r_result <= w_result;
    end
  end

  assign stall_o  = (r_state == ST_IDLE && w_accept) ||
                    (r_state == ST_PREP) || (r_state == ST_CALC);
  assign done_o   = (r_state == ST_DONE);
  assign result_o = r_result;

endmodule

`default_nettype wire
